mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IFU fetch path and the LSU load/store path.
- Sits between the fetch stage and the EX-stage LSU on one side and the external memory bus on the other.
- Sequences one outstanding bus transaction at a time with a 3-state FSM.
- LSU has fixed priority over fetch, bounded by an anti-starvation streak counter.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while a fetch is waiting.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clock_in  in  1  system clock.
- reset_in  in  1  synchronous, active-low reset.
- ifu_req_in  in  1  fetch request.
- ifu_addr_in  in  ADDR_WIDTH  fetch address.
- ifu_flush_in  in  1  kill the in-flight fetch.
- ifu_gnt_out  out  1  fetch accepted this cycle.
- ifu_valid_out  out  1  fetch data valid (1-cycle pulse).
- ifu_data_out  out  DATA_WIDTH  fetched instruction.
- lsu_req_in  in  1  load/store request.
- lsu_we_in  in  1  1 = store.
- lsu_addr_in  in  ADDR_WIDTH  load/store address.
- lsu_wdata_in  in  DATA_WIDTH  store data.
- lsu_be_in  in  DATA_WIDTH/8  byte enables.
- lsu_gnt_out  out  1  LSU request accepted this cycle.
- lsu_valid_out  out  1  load data valid / store done (1-cycle pulse).
- lsu_data_out  out  DATA_WIDTH  load data.
- mem_req_out  out  1  bus request.
- mem_we_out  out  1  bus write.
- mem_addr_out  out  ADDR_WIDTH  bus address.
- mem_wdata_out  out  DATA_WIDTH  bus write data.
- mem_be_out  out  DATA_WIDTH/8  bus byte enables.
- mem_ack_in  in  1  bus completion.
- mem_rdata_in  in  DATA_WIDTH  bus read data.
- busy_out  out  1  FSM not in IDLE (pipeline stall hint).
- err_out  out  1  watchdog abort pulse.

Behaviour:
- FSM states: IDLE, IFU_BUSY, LSU_BUSY. Reset state is IDLE.
- Reset values: all outputs 0, streak counter 0, drop flag 0.
- Grant is combinational and only issued in IDLE:
  - If lsu_req_in=1 and not (streak==MAX_LSU_STREAK and ifu_req_in=1): assert lsu_gnt_out and go to LSU_BUSY.
  - Else if ifu_req_in=1: assert ifu_gnt_out and go to IFU_BUSY.
  - Never both grants in the same cycle.
- On grant, the address, we, wdata and be of the winner are registered into the mem_* outputs.
- mem_req_out=1 from grant cycle +1 and is held, with stable fields, until a cycle with mem_ack_in=1.
- mem_ack_in while mem_req_out=0 is ignored.
- Ack cycle A:
  - Capture mem_rdata_in.
  - mem_req_out drops at A+1.
  - The owner's valid_out pulses at A+1 with the captured data.
  - State returns to IDLE at A+1, so a new grant is possible in A+1.
- Minimum latency: zero-wait memory gives grant T, mem_req T+1, valid T+2; throughput is one transaction per 2 cycles.
- Stores: lsu_valid_out pulses exactly as for loads; lsu_data_out holds the captured bus value.
- Streak counter:
  - Increments, saturating at MAX_LSU_STREAK, on each LSU grant with ifu_req_in=1.
  - Clears on every IFU grant.
  - Clears on an LSU grant with ifu_req_in=0.
- Flush:
  - ifu_flush_in=1 during IFU_BUSY, or in the ack cycle of a fetch, sets the drop flag.
  - With the drop flag set, the bus transaction still completes, but ifu_valid_out is suppressed.
  - The drop flag clears on return to IDLE.
  - Flush during IDLE or LSU_BUSY has no effect.
- busy_out = (state != IDLE).
- Requesters must hold req and addr until their gnt; a req that is withdrawn before gnt is lost.
- Reset mid-transaction: the next cycle is IDLE, mem_req_out=0 and no valid pulse is issued. The external bus must tolerate the abandoned request.
- Data outputs hold their last value between pulses.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on grant and increments while mem_req_out=1 without ack.
  - On reaching TIMEOUT_CYCLES: drop mem_req_out, pulse err_out, and return to IDLE next cycle.
  - On abort, the owner's valid_out pulses with data 32'h00000013 (NOP) for IFU, or 0 for LSU.
  - IFU abort still honours the drop flag.
- When undefined: no counter is built, err_out is tied to 0, and the FSM waits for ack indefinitely.

Test Plan:
1. Zero-wait fetch: ifu_req_in=1, addr 0x100, ack immediate, rdata 0x00500093 -> ifu_gnt T0, mem_req T1 with addr 0x100, ifu_valid T2 with data 0x00500093.
2. Simultaneous ifu_req and lsu_req (load 0x2000) -> lsu_gnt first, mem_we=0, lsu_valid carries rdata; the next IDLE cycle grants the IFU.
3. Starvation: lsu_req and ifu_req held high with MAX_LSU_STREAK=4 -> LSU granted 4 times, 5th grant goes to IFU, then LSU again.
4. Flush: fetch with 3 wait cycles and ifu_flush_in pulsed in the 2nd -> mem ack occurs, ifu_valid_out stays 0, state IDLE afterwards.
5. Store with be=4'b0011 and wdata 0xDEADBEEF -> mem_we=1, be=0011 held stable until ack, lsu_valid pulses once.
6. Reset mid-LSU_BUSY: reset_in=0 for 1 cycle -> mem_req_out=0 next cycle, no valid pulse. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no ack -> err_out pulse after 8 cycles, ifu_data_out=0x00000013.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the IFU fetch path and the
// EX-stage LSU. One bus transaction is outstanding at a time. The LSU has fixed
// priority, but after MAX_LSU_STREAK consecutive LSU wins over a waiting fetch the
// fetch is granted once.
//
// Ports:
//   clock_in, reset_in          clock, synchronous active-low reset
//   ifu_req/addr/flush_in       fetch request, address, kill of the in-flight fetch
//   ifu_gnt/valid/data_out      fetch accepted, fetch data pulse and data
//   lsu_req/we/addr/wdata/be_in load/store request
//   lsu_gnt/valid/data_out      LSU accepted, completion pulse and load data
//   mem_*_out, mem_ack_in,
//   mem_rdata_in                external memory bus (request held until ack)
//   busy_out                    arbiter owns the bus (stall hint)
//   err_out                     watchdog abort pulse
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to build a bus watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles without ack. Without it err_out is tied low
// and the arbiter waits for ack indefinitely.

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_LSU_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clock_in,
    input  logic                    reset_in,

    input  logic                    ifu_req_in,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr_in,
    input  logic                    ifu_flush_in,
    output logic                    ifu_gnt_out,
    output logic                    ifu_valid_out,
    output logic [DATA_WIDTH-1:0]   ifu_data_out,

    input  logic                    lsu_req_in,
    input  logic                    lsu_we_in,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_in,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_in,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_in,
    output logic                    lsu_gnt_out,
    output logic                    lsu_valid_out,
    output logic [DATA_WIDTH-1:0]   lsu_data_out,

    output logic                    mem_req_out,
    output logic                    mem_we_out,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    output logic [DATA_WIDTH-1:0]   mem_wdata_out,
    output logic [DATA_WIDTH/8-1:0] mem_be_out,
    input  logic                    mem_ack_in,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_in,

    output logic                    busy_out,
    output logic                    err_out
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_LSU_STREAK + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IFU_BUSY = 2'd1;
    localparam logic [1:0] LSU_BUSY = 2'd2;

    // Returned to the IFU on a watchdog abort so the pipeline executes a harmless NOP.
    localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);

    logic [1:0]            state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  drop_q, drop_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
    logic                  ifu_valid_q, ifu_valid_d;
    logic [DATA_WIDTH-1:0] ifu_data_q, ifu_data_d;
    logic                  lsu_valid_q, lsu_valid_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;

    logic                  idle;
    logic                  streak_full;
    logic                  lsu_wins;
    logic                  ack;
    logic                  abort;
    logic                  done;
    logic                  drop_now;
    logic [DATA_WIDTH-1:0] resp_data;

    assign idle        = (state_q == IDLE);
    assign streak_full = (streak_q == STREAK_W'(MAX_LSU_STREAK));
    // LSU loses only when its streak is exhausted and a fetch is actually waiting.
    assign lsu_wins    = lsu_req_in && !(streak_full && ifu_req_in);
    assign lsu_gnt_out = reset_in && idle && lsu_wins;
    assign ifu_gnt_out = reset_in && idle && !lsu_wins && ifu_req_in;

    // An ack is only meaningful while a request is on the bus.
    assign ack       = mem_req_q && mem_ack_in;
    assign done      = ack || abort;
    assign drop_now  = drop_q || (ifu_flush_in && (state_q == IFU_BUSY));
    assign resp_data = ack ? mem_rdata_in :
                       ((state_q == IFU_BUSY) ? NOP_INSN : '0);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q;

    assign abort = mem_req_q && !mem_ack_in && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q;
        if (lsu_gnt_out || ifu_gnt_out) begin
            wdog_d = '0;
        end else if (mem_req_q && !mem_ack_in) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= abort;
        end
    end

    assign err_out = err_q;
`else
    assign abort   = 1'b0;
    assign err_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        ifu_valid_d = 1'b0;
        ifu_data_d  = ifu_data_q;
        lsu_valid_d = 1'b0;
        lsu_data_d  = lsu_data_q;

        case (state_q)
            IDLE: begin
                if (lsu_gnt_out) begin
                    state_d     = LSU_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = lsu_we_in;
                    mem_addr_d  = lsu_addr_in;
                    mem_wdata_d = lsu_wdata_in;
                    mem_be_d    = lsu_be_in;
                    if (!ifu_req_in) begin
                        streak_d = '0;
                    end else if (!streak_full) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (ifu_gnt_out) begin
                    state_d     = IFU_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ifu_addr_in;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_d    = '0;
                end
            end
            IFU_BUSY: begin
                drop_d = drop_now;
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_now) begin
                        ifu_valid_d = 1'b1;
                        ifu_data_d  = resp_data;
                    end
                end
            end
            LSU_BUSY: begin
                if (done) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    lsu_valid_d = 1'b1;
                    lsu_data_d  = resp_data;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            ifu_valid_q <= 1'b0;
            ifu_data_q  <= '0;
            lsu_valid_q <= 1'b0;
            lsu_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            ifu_valid_q <= ifu_valid_d;
            ifu_data_q  <= ifu_data_d;
            lsu_valid_q <= lsu_valid_d;
            lsu_data_q  <= lsu_data_d;
        end
    end

    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_be_out    = mem_be_q;
    assign ifu_valid_out = ifu_valid_q;
    assign ifu_data_out  = ifu_data_q;
    assign lsu_valid_out = lsu_valid_q;
    assign lsu_data_out  = lsu_data_q;
    assign busy_out      = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a bus responder answers requests with data derived
// from the address, expected responses are queued per requester when a grant is seen
// or stimulus is driven, and a monitor pops and compares them on each valid pulse.
// Build with MEM_ARB_TIMEOUT_EN defined to add the watchdog abort scenario.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, ifu_flush, ifu_gnt, ifu_valid;
    logic [31:0] ifu_addr, ifu_data;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_data;
    logic [3:0]  lsu_be;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy, err;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] ifu_q[$];
    logic [31:0] lsu_q[$];

    int bus_wait  = 0;
    bit bus_hang  = 0;
    bit spurious  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MAX_LSU_STREAK(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock_in     (clk),
        .reset_in     (rst_n),
        .ifu_req_in   (ifu_req),
        .ifu_addr_in  (ifu_addr),
        .ifu_flush_in (ifu_flush),
        .ifu_gnt_out  (ifu_gnt),
        .ifu_valid_out(ifu_valid),
        .ifu_data_out (ifu_data),
        .lsu_req_in   (lsu_req),
        .lsu_we_in    (lsu_we),
        .lsu_addr_in  (lsu_addr),
        .lsu_wdata_in (lsu_wdata),
        .lsu_be_in    (lsu_be),
        .lsu_gnt_out  (lsu_gnt),
        .lsu_valid_out(lsu_valid),
        .lsu_data_out (lsu_data),
        .mem_req_out  (mem_req),
        .mem_we_out   (mem_we),
        .mem_addr_out (mem_addr),
        .mem_wdata_out(mem_wdata),
        .mem_be_out   (mem_be),
        .mem_ack_in   (mem_ack),
        .mem_rdata_in (mem_rdata),
        .busy_out     (busy),
        .err_out      (err)
    );

    function automatic logic [31:0] bus_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
    endfunction

    // Memory bus: acks after bus_wait idle cycles, never acks while bus_hang is set.
    task automatic run_responder();
        int w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && !bus_hang) begin
                if (w >= bus_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bus_model(mem_addr);
                    w = 0;
                end else begin
                    mem_ack = 1'b0;
                    w++;
                end
            end else begin
                mem_ack   = spurious && (mem_req !== 1'b1);
                mem_rdata = 32'hBAD0_BAD0;
                w = 0;
            end
        end
    endtask

    // Scoreboard and per-cycle protocol checks.
    task automatic run_monitor();
        bit          pend = 0;
        logic [72:0] pend_fields = '0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            n_checks++;
            if ((ifu_gnt && lsu_gnt) !== 1'b0) begin
                n_fails++;
                $display("FAIL both_gnt: ifu_gnt=%b lsu_gnt=%b required not both", ifu_gnt, lsu_gnt);
            end
            if (ifu_valid === 1'b1) begin
                n_checks++;
                if (ifu_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL ifu_unexpected_valid: data=%h required no pulse", ifu_data);
                end else begin
                    exp = ifu_q.pop_front();
                    if (ifu_data !== exp) begin
                        n_fails++;
                        $display("FAIL ifu_data: got %h required %h", ifu_data, exp);
                    end
                end
            end
            if (lsu_valid === 1'b1) begin
                n_checks++;
                if (lsu_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL lsu_unexpected_valid: data=%h required no pulse", lsu_data);
                end else begin
                    exp = lsu_q.pop_front();
                    if (lsu_data !== exp) begin
                        n_fails++;
                        $display("FAIL lsu_data: got %h required %h", lsu_data, exp);
                    end
                end
            end
`ifndef MEM_ARB_TIMEOUT_EN
            if (pend) begin
                n_checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== pend_fields) begin
                    n_fails++;
                    $display("FAIL mem_stable: got %h required %h",
                             {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, pend_fields);
                end
            end
            n_checks++;
            if (err !== 1'b0) begin
                n_fails++;
                $display("FAIL err_tied: got %b required 0", err);
            end
`endif
            pend = (mem_req === 1'b1) && (mem_ack !== 1'b1) && (rst_n === 1'b1);
            pend_fields = {mem_req, mem_we, mem_addr, mem_wdata, mem_be};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifu_req = 0; ifu_flush = 0; ifu_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ifu_gnt, ifu_valid, ifu_data, lsu_gnt, lsu_valid, lsu_data, mem_req, mem_we,
             mem_addr, mem_wdata, mem_be, busy, err} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: some output nonzero (busy=%b mem_req=%b data=%h) required all 0",
                     busy, mem_req, ifu_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, mem_req} !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_release_idle: busy=%b mem_req=%b required 0 0", busy, mem_req);
        end
    endtask

    task automatic test_zero_wait_fetch();
        bus_wait = 0;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h100;
        ifu_q.push_back(32'h0050_0093);
        @(negedge clk);
        n_checks++;
        if ({ifu_gnt, lsu_gnt, mem_req} !== 3'b100) begin
            n_fails++;
            $display("FAIL fetch_gnt_T0: gnt/lsu_gnt/mem_req=%b required 100", {ifu_gnt, lsu_gnt, mem_req});
        end
        @(posedge clk); #1;
        ifu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, busy, mem_addr} !== {3'b101, 32'h100}) begin
            n_fails++;
            $display("FAIL fetch_mem_T1: req/we/busy=%b addr=%h required 101 00000100",
                     {mem_req, mem_we, busy}, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({ifu_valid, mem_req, busy} !== 3'b100) begin
            n_fails++;
            $display("FAIL fetch_valid_T2: valid/mem_req/busy=%b required 100", {ifu_valid, mem_req, busy});
        end
    endtask

    task automatic test_priority();
        bus_wait = 0;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h104;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h2000; lsu_be = 4'hF;
        lsu_q.push_back(bus_model(32'h2000));
        @(negedge clk);
        n_checks++;
        if ({lsu_gnt, ifu_gnt} !== 2'b10) begin
            n_fails++;
            $display("FAIL prio_lsu_first: lsu_gnt/ifu_gnt=%b required 10", {lsu_gnt, ifu_gnt});
        end
        @(posedge clk); #1;
        lsu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, ifu_gnt} !== {2'b10, 32'h2000, 1'b0}) begin
            n_fails++;
            $display("FAIL prio_load_bus: req/we=%b addr=%h ifu_gnt=%b required 10 00002000 0",
                     {mem_req, mem_we}, mem_addr, ifu_gnt);
        end
        ifu_q.push_back(bus_model(32'h104));
        @(negedge clk);
        n_checks++;
        if ({lsu_valid, ifu_gnt} !== 2'b11) begin
            n_fails++;
            $display("FAIL prio_then_ifu: lsu_valid/ifu_gnt=%b required 11", {lsu_valid, ifu_gnt});
        end
        @(posedge clk); #1;
        ifu_req = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ifu_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL prio_ifu_valid: got %b required 1", ifu_valid);
        end
    endtask

    task automatic test_starvation();
        bit exp_lsu[6] = '{1, 1, 1, 1, 0, 1};
        int got = 0;
        bus_wait = 0;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h200;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h3000;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (ifu_gnt === 1'b1 || lsu_gnt === 1'b1) begin
                n_checks++;
                if (lsu_gnt !== exp_lsu[got]) begin
                    n_fails++;
                    $display("FAIL starve_grant%0d: lsu_gnt=%b required %b", got, lsu_gnt, exp_lsu[got]);
                end
                if (lsu_gnt === 1'b1) lsu_q.push_back(bus_model(32'h3000));
                else ifu_q.push_back(bus_model(32'h200));
                got++;
            end
        end
        n_checks++;
        if (got != 6) begin
            n_fails++;
            $display("FAIL starve_budget: got %0d grants required 6", got);
        end
        @(posedge clk); #1;
        ifu_req = 0; lsu_req = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_flush();
        int pulses = 0;
        bus_wait = 3;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h300;
        @(negedge clk);
        n_checks++;
        if (ifu_gnt !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_gnt: got %b required 1", ifu_gnt);
        end
        @(posedge clk); #1;
        ifu_req = 0;
        @(posedge clk); #1;
        ifu_flush = 1;
        @(posedge clk); #1;
        ifu_flush = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_ack} !== 2'b11) begin
            n_fails++;
            $display("FAIL flush_ack_T4: req/ack=%b required 11", {mem_req, mem_ack});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifu_valid === 1'b1) pulses++;
        end
        n_checks++;
        if ({pulses[3:0], busy, mem_req} !== 6'b0) begin
            n_fails++;
            $display("FAIL flush_dropped: pulses=%0d busy=%b mem_req=%b required 0 0 0",
                     pulses, busy, mem_req);
        end
        // Drop flag must not leak into the next fetch.
        bus_wait = 0;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h304;
        ifu_q.push_back(bus_model(32'h304));
        @(posedge clk); #1;
        ifu_req = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ifu_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_next_fetch: valid=%b required 1", ifu_valid);
        end
    endtask

    task automatic test_store();
        int pulses = 0;
        bus_wait = 2;
        @(posedge clk); #1;
        lsu_req = 1; lsu_we = 1; lsu_addr = 32'h4000; lsu_wdata = 32'hDEAD_BEEF; lsu_be = 4'b0011;
        lsu_q.push_back(bus_model(32'h4000));
        @(negedge clk);
        n_checks++;
        if (lsu_gnt !== 1'b1) begin
            n_fails++;
            $display("FAIL store_gnt: got %b required 1", lsu_gnt);
        end
        @(posedge clk); #1;
        lsu_req = 0; lsu_we = 0; lsu_addr = 32'hFFFF_0000; lsu_wdata = 32'h1234_5678; lsu_be = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {2'b11, 4'b0011, 32'hDEAD_BEEF, 32'h4000}) begin
                n_fails++;
                $display("FAIL store_bus_c%0d: req/we=%b be=%b wdata=%h addr=%h required 11 0011 deadbeef 00004000",
                         i, {mem_req, mem_we}, mem_be, mem_wdata, mem_addr);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lsu_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fails++;
            $display("FAIL store_valid_once: got %0d pulses required 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus_hang = 1;
        @(posedge clk); #1;
        lsu_req = 1; lsu_we = 0; lsu_addr = 32'h5000; lsu_be = 4'hF;
        @(posedge clk); #1;
        lsu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, busy} !== 2'b11) begin
            n_fails++;
            $display("FAIL rstmid_busy: req/busy=%b required 11", {mem_req, busy});
        end
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        bus_hang = 0;
        @(negedge clk);
        n_checks++;
        if ({mem_req, busy} !== 2'b00) begin
            n_fails++;
            $display("FAIL rstmid_idle: req/busy=%b required 00", {mem_req, busy});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lsu_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fails++;
            $display("FAIL rstmid_no_valid: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_spurious_ack();
        spurious = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, mem_req, ifu_valid, lsu_valid} !== 4'b0) begin
                n_fails++;
                $display("FAIL spurious_ack_c%0d: busy/req/ivalid/lvalid=%b required 0000",
                         i, {busy, mem_req, ifu_valid, lsu_valid});
            end
        end
        spurious = 0;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus_hang = 1;
        @(posedge clk); #1;
        ifu_req = 1; ifu_addr = 32'h600;
        ifu_q.push_back(32'h0000_0013);
        @(posedge clk); #1;
        ifu_req = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < 9 && {err, mem_req} !== 2'b01) begin
                n_fails++;
                $display("FAIL timeout_wait_c%0d: err/req=%b required 01", k, {err, mem_req});
            end else if (k == 9 && {err, mem_req, ifu_valid, ifu_data} !== {3'b101, 32'h13}) begin
                n_fails++;
                $display("FAIL timeout_abort: err/req/valid=%b data=%h required 101 00000013",
                         {err, mem_req, ifu_valid}, ifu_data);
            end
        end
        bus_hang = 0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        mem_ack = 0;
        mem_rdata = '0;
        fork
            run_responder();
            run_monitor();
        join_none
        test_reset();
        test_zero_wait_fetch();
        test_priority();
        test_starvation();
        test_flush();
        test_store();
        test_reset_mid();
        test_spurious_ack();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        n_checks++;
        if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: ifu left %0d lsu left %0d required 0 0",
                     ifu_q.size(), lsu_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
